reset_controller: RTL and testbench

RESET_CONTROLLER -- requirements
Module: reset_controller

---
 rtl/reset_controller_if.sv | 10 +
 rtl/reset_controller.sv | 62 ++++++
 tb/tb_reset_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reset_controller_if.sv
// reset_controller_if: software-reset handshake and chip reset status bundle.
interface reset_controller_if;
    logic       SwResetReq;
    logic       SysReset;
    logic       Ready;
    logic       SwResetAck;
    logic [1:0] ResetCause;
    modport master (output SwResetReq, input SysReset, Ready, SwResetAck, ResetCause);
    modport slave (input SwResetReq, output SysReset, Ready, SwResetAck, ResetCause);
endinterface

// File: rtl/reset_controller.sv
// reset_controller: async-assert/sync-release chip reset with stretch and software reset.
module reset_controller #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int SW_HOLD     = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    reset_controller_if.slave  bus
);
    localparam int MAXV = HOLD_CYCLES > SW_HOLD ? HOLD_CYCLES : SW_HOLD;
    localparam int CW = MAXV > 1 ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] CMAX = CW'(MAXV - 1);
    localparam logic [CW-1:0] HMAX = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SMAX = CW'(SW_HOLD - 1);
    typedef enum logic [2:0] {ASSERT, SYNC, HOLD, RUN, SWRST} state_t;
    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= ASSERT;
            sync           <= '0;
            cnt            <= '0;
            bus.SysReset   <= 1'b1;
            bus.Ready      <= 1'b0;
            bus.SwResetAck <= 1'b0;
            bus.ResetCause <= 2'b01;
        end else begin
            sync           <= {sync[SYNC_STAGES-2:0], 1'b1};
            bus.SwResetAck <= 1'b0;
            cnt            <= cnt == CMAX ? cnt : cnt + CW'(1);
            case (state)
                ASSERT: state <= SYNC;
                // last stage becomes 1 on this edge
                SYNC: if (sync[SYNC_STAGES-2]) begin
                    state <= HOLD;
                    cnt   <= '0;
                end
                HOLD: if (cnt == HMAX) begin
                    state        <= RUN;
                    bus.SysReset <= 1'b0;
                    bus.Ready    <= 1'b1;
                end
                RUN: if (bus.SwResetReq) begin
                    state          <= SWRST;
                    cnt            <= '0;
                    bus.SysReset   <= 1'b1;
                    bus.Ready      <= 1'b0;
                    bus.SwResetAck <= 1'b1;
                    bus.ResetCause <= 2'b10;
                end
                SWRST: if (cnt >= SMAX && !bus.SwResetReq) begin
                    state        <= RUN;
                    bus.SysReset <= 1'b0;
                    bus.Ready    <= 1'b1;
                end
                default: state <= ASSERT;
            endcase
        end
    end
endmodule

// File: tb/tb_reset_controller.sv
// tb_reset_controller: vector table, directed corner sequences and randomized model check.
module tb_reset_controller;
    localparam int S = 2, H = 16, W = 4;
    logic Clock = 1'b0;
    logic Reset;
    int checks = 0, errors = 0;
    reset_controller_if bus ();
    reset_controller #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .SW_HOLD(W)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );
    always #5 Clock = ~Clock;
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    // reference: counts edges since release and edges since software entry
    int         boot_n, sw_n;
    bit         booted, in_sw;
    logic [4:0] exp_o;
    function automatic void model_reset();
        boot_n = 0;
        sw_n   = 0;
        booted = 1'b0;
        in_sw  = 1'b0;
        exp_o  = 5'b10001;
    endfunction
    function automatic void model_edge(input bit req);
        exp_o[2] = 1'b0;
        if (!booted) begin
            boot_n++;
            if (boot_n == S + H) begin
                booted = 1'b1;
                exp_o[4:3] = 2'b01;
            end
        end else if (!in_sw) begin
            if (req) begin
                in_sw = 1'b1;
                sw_n  = 0;
                exp_o = 5'b10110;
            end
        end else begin
            sw_n++;
            if (sw_n >= W && !req) begin
                in_sw = 1'b0;
                exp_o[4:3] = 2'b01;
            end
        end
    endfunction
    function automatic logic [4:0] outs();
        return {bus.SysReset, bus.Ready, bus.SwResetAck, bus.ResetCause};
    endfunction
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction
    task automatic tick(input bit req);
        bus.SwResetReq = req;
        @(posedge Clock);
        if (!Reset) model_edge(req);
        #1;
        check("model", {27'd0, outs()}, {27'd0, exp_o});
    endtask
    task automatic assert_reset();
        Reset = 1'b1;
        model_reset();
    endtask
    task automatic boot();
        assert_reset();
        tick(0);
        tick(0);
        Reset = 1'b0;
        repeat (S + H) tick(0);
    endtask
    task automatic held(input int n);
        int acks = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            acks += int'(bus.SwResetAck);
            check("held_sys", {31'd0, bus.SysReset}, 32'd1);
        end
        tick(0);
        check("held_release", {27'd0, outs()}, {27'd0, 5'b01010});
        check("held_acks", acks, 32'd1);
    endtask
    typedef struct {
        bit         req;
        logic [4:0] exp;
    } vec_t;
    vec_t tv[11];
    initial begin
        int n, acks;
        tv = '{'{1, 5'b10110}, '{0, 5'b10010}, '{0, 5'b10010}, '{0, 5'b10010},
               '{0, 5'b01010}, '{0, 5'b01010}, '{1, 5'b10110}, '{1, 5'b10010},
               '{0, 5'b10010}, '{0, 5'b10010}, '{0, 5'b01010}};
        bus.SwResetReq = 1'b0;
        assert_reset();
        repeat (5) tick(0);
        check("reset_state", {27'd0, outs()}, {27'd0, 5'b10001});
        Reset = 1'b0;
        for (int i = 1; i <= S + H; i++) begin
            tick(0);
            check("por_sys", {31'd0, bus.SysReset}, {31'd0, i < S + H});
        end
        check("por_run", {27'd0, outs()}, {27'd0, 5'b01001});
        for (int i = 0; i < 11; i++) begin
            tick(tv[i].req);
            check($sformatf("vec%0d", i), {27'd0, outs()}, {27'd0, tv[i].exp});
        end
        held(10);
        held(17);
        boot();
        repeat (10) tick(0);
        assert_reset();
        #1;
        check("abort_assert", {27'd0, outs()}, {27'd0, 5'b10001});
        tick(0);
        Reset = 1'b0;
        n = 0;
        while (bus.SysReset && n < 40) begin
            tick(0);
            n++;
        end
        check("abort_release", n, S + H);
        check("abort_cause", {30'd0, bus.ResetCause}, 32'd1);
        assert_reset();
        tick(0);
        Reset = 1'b0;
        acks = 0;
        for (int i = 1; i <= S + H; i++) begin
            tick(1);
            acks += int'(bus.SwResetAck);
            check("ign_sys", {31'd0, bus.SysReset}, {31'd0, i < S + H});
        end
        check("ign_acks", acks, 32'd0);
        check("ign_run", {27'd0, outs()}, {27'd0, 5'b01001});
        tick(0);
        #3;
        assert_reset();
        #1;
        check("async_assert", {27'd0, outs()}, {27'd0, 5'b10001});
        tick(0);
        Reset = 1'b0;
        repeat (S + H) tick(0);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                assert_reset();
                repeat ($urandom_range(1, 3)) tick($urandom_range(0, 1) == 1);
                Reset = 1'b0;
            end
            if ($urandom_range(0, 59) == 0) repeat ($urandom_range(5, 20)) tick(1);
            tick($urandom_range(0, 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
